fifo_rr_frame_arb: RTL and testbench

Frame-level round-robin arbiter that drains C_NUM_PORTS first-word-fall-through FIFO read ports into one valid/ready output stream. It sits on the read-clock side of the per-port ingress FIFOs, ahead of the switch forwarding pipeline. Frames are never interleaved. A per-frame word limit truncates runaway frames and discards their remainder, so one port cannot hold the output indefinitely.

---
 rtl/fifo_rr_frame_arb_pkg.sv | 26 ++
 rtl/fifo_rr_frame_arb_rr_pick.sv | 33 +++
 rtl/fifo_rr_frame_arb.sv | 142 ++++++++++++++
 tb/tb_fifo_rr_frame_arb.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rr_frame_arb_pkg.sv
// Shared types and helpers for the frame-level round-robin FIFO arbiter.
package fifo_rr_frame_arb_pkg;

  // Controller states; encodings are fixed so they read the same in any waveform viewer.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  // Bit index of the end-of-frame flag inside a FIFO word.
  function automatic int last_bit(input int width);
    return width - 1;
  endfunction

  // Ceiling log2, used to size index and counter fields from the parameters.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_rr_frame_arb_rr_pick.sv
// Rotate-priority selector: the first requesting port above last_grant wins, wrapping.
module fifo_rr_frame_arb_rr_pick #(
  parameter int C_NUM_PORTS = 4,
  parameter int C_PORT_BITS = 2
) (
  input  logic [C_NUM_PORTS-1:0] req,
  input  logic [C_PORT_BITS-1:0] last_grant,
  output logic [C_PORT_BITS-1:0] grant,
  output logic                   any
);

  // Scan offsets from farthest to nearest so the nearest requester overwrites the rest.
  always_comb begin
    int                   idx;
    logic [C_PORT_BITS-1:0] pidx;
    grant = '0;
    any   = 1'b0;
    idx   = 0;
    pidx  = '0;
    for (int k = C_NUM_PORTS; k >= 1; k--) begin
      idx = int'(last_grant) + k;
      if (idx >= C_NUM_PORTS) begin
        idx = idx - C_NUM_PORTS;
      end
      pidx = C_PORT_BITS'(idx);
      if (req[pidx]) begin
        grant = pidx;
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_frame_arb.sv
// Frame-level round-robin arbiter draining FWFT FIFO read ports into one
// valid/ready stream, with per-frame word limit and discard of the overflow.
module fifo_rr_frame_arb
  import fifo_rr_frame_arb_pkg::*;
#(
  parameter int C_NUM_PORTS = 4,
  parameter int C_WIDTH     = 33,
  parameter int C_MAX_WORDS = 1024,
  parameter int C_PORT_BITS = clog2(C_NUM_PORTS),
  parameter int C_CNT_BITS  = clog2(C_MAX_WORDS + 1)
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [C_NUM_PORTS-1:0]         PORT_EN,
  input  logic [C_NUM_PORTS*C_WIDTH-1:0] FIFO_DATA,
  input  logic [C_NUM_PORTS-1:0]         FIFO_EMPTY,
  output logic [C_NUM_PORTS-1:0]         FIFO_RD_EN,
  output logic [C_WIDTH-2:0]             OUT_DATA,
  output logic                           OUT_LAST,
  output logic                           OUT_VALID,
  input  logic                           OUT_READY,
  output logic [C_PORT_BITS-1:0]         OUT_SRC,
  output logic                           TRUNC,
  output logic                           BUSY
);

  localparam int                    LAST_BIT = last_bit(C_WIDTH);
  localparam logic [C_CNT_BITS-1:0] LIMIT    = C_CNT_BITS'(C_MAX_WORDS - 1);

  state_t                  state_reg;
  logic [C_PORT_BITS-1:0]  grant_reg;
  logic [C_PORT_BITS-1:0]  last_grant_reg;
  logic [C_CNT_BITS-1:0]   word_cnt_reg;
  logic                    trunc_reg;
  logic                    busy_reg;

  logic [C_WIDTH-1:0]      port_word [C_NUM_PORTS];
  logic [C_NUM_PORTS-1:0]  req;
  logic [C_PORT_BITS-1:0]  pick_grant;
  logic                    pick_any;
  logic [C_WIDTH-1:0]      sel_word;
  logic                    sel_empty;
  logic                    sel_last;
  logic                    at_limit;
  logic                    out_valid;
  logic                    beat;
  logic                    pop;

  // Unpack the concatenated FIFO bus and fan the single pop strobe out to the granted port.
  genvar gi;
  generate
    for (gi = 0; gi < C_NUM_PORTS; gi++) begin : g_port
      assign port_word[gi]  = FIFO_DATA[gi*C_WIDTH +: C_WIDTH];
      assign FIFO_RD_EN[gi] = pop && (grant_reg == C_PORT_BITS'(gi));
    end
  endgenerate

  assign req = ~FIFO_EMPTY & PORT_EN;

  fifo_rr_frame_arb_rr_pick #(
    .C_NUM_PORTS (C_NUM_PORTS),
    .C_PORT_BITS (C_PORT_BITS)
  ) u_pick (
    .req        (req),
    .last_grant (last_grant_reg),
    .grant      (pick_grant),
    .any        (pick_any)
  );

  assign sel_word  = port_word[grant_reg];
  assign sel_empty = FIFO_EMPTY[grant_reg];
  assign sel_last  = sel_word[LAST_BIT];
  assign at_limit  = (word_cnt_reg == LIMIT);
  assign out_valid = (state_reg == ST_XFER) && !sel_empty;
  assign beat      = out_valid && OUT_READY;

  assign OUT_VALID = out_valid;
  assign OUT_DATA  = sel_word[C_WIDTH-2:0];
  assign OUT_LAST  = out_valid && (sel_last || at_limit);
  assign OUT_SRC   = grant_reg;
  assign TRUNC     = trunc_reg;
  assign BUSY      = busy_reg;

  // Pop on accepted beats while forwarding; pop whatever is present while discarding.
  always_comb begin
    pop = 1'b0;
    case (state_reg)
      ST_XFER: pop = beat;
      ST_DROP: pop = !sel_empty;
      default: pop = 1'b0;
    endcase
  end

  // Frame controller: grant in IDLE, forward in XFER, discard the truncated tail in DROP.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg      <= ST_IDLE;
      grant_reg      <= '0;
      last_grant_reg <= C_PORT_BITS'(C_NUM_PORTS - 1);
      word_cnt_reg   <= '0;
      trunc_reg      <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      trunc_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (pick_any) begin
            grant_reg      <= pick_grant;
            last_grant_reg <= pick_grant;
            word_cnt_reg   <= '0;
            state_reg      <= ST_XFER;
            busy_reg       <= 1'b1;
          end
        end
        ST_XFER: begin
          if (beat) begin
            word_cnt_reg <= word_cnt_reg + C_CNT_BITS'(1);
            if (sel_last) begin
              // A real end flag on the limit word is a complete frame, not a truncation.
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
            end else if (at_limit) begin
              trunc_reg <= 1'b1;
              state_reg <= ST_DROP;
            end
          end
        end
        ST_DROP: begin
          if (!sel_empty && sel_last) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rr_frame_arb.sv
// Directed scoreboard bench for fifo_rr_frame_arb with 4 ports, 9-bit words, 4-word frame limit.
module tb_fifo_rr_frame_arb;

  localparam int NP  = 4;
  localparam int W   = 9;
  localparam int MAX = 4;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic [1:0] src;
  } beat_t;

  logic          CLK;
  logic          RST;
  logic [NP-1:0] PORT_EN;
  logic [NP*W-1:0] FIFO_DATA;
  logic [NP-1:0] FIFO_EMPTY;
  logic [NP-1:0] FIFO_RD_EN;
  logic [W-2:0]  OUT_DATA;
  logic          OUT_LAST;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic [1:0]    OUT_SRC;
  logic          TRUNC;
  logic          BUSY;

  logic [W-1:0]  fifo_q [NP][$];
  beat_t         exp_q [$];
  logic [5:0]    seq_ctr;
  int            n_vec;
  int            n_err;
  int            trunc_cnt;
  int            stall_cnt;

  fifo_rr_frame_arb #(
    .C_NUM_PORTS (NP),
    .C_WIDTH     (W),
    .C_MAX_WORDS (MAX),
    .C_PORT_BITS (2),
    .C_CNT_BITS  (3)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .PORT_EN    (PORT_EN),
    .FIFO_DATA  (FIFO_DATA),
    .FIFO_EMPTY (FIFO_EMPTY),
    .FIFO_RD_EN (FIFO_RD_EN),
    .OUT_DATA   (OUT_DATA),
    .OUT_LAST   (OUT_LAST),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .OUT_SRC    (OUT_SRC),
    .TRUNC      (TRUNC),
    .BUSY       (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end of the sequence");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Present the head of each modelled FWFT FIFO to the DUT.
  task automatic refresh();
    for (int i = 0; i < NP; i++) begin
      FIFO_EMPTY[i] = (fifo_q[i].size() == 0);
      FIFO_DATA[i*W +: W] = (fifo_q[i].size() != 0) ? fifo_q[i][0] : '0;
    end
  endtask

  task automatic load_frame(input int port, input int n, output logic [5:0] start);
    logic [W-1:0] w;
    start = seq_ctr;
    for (int k = 0; k < n; k++) begin
      w = {(k == n - 1), 2'(port), seq_ctr};
      fifo_q[port].push_back(w);
      seq_ctr = seq_ctr + 6'd1;
    end
    refresh();
  endtask

  // Expected beats of a frame of 'total' words starting at word 'skip', at most 'maxn' of them.
  task automatic expect_frame(input int port, input logic [5:0] start, input int total,
                              input int skip, input int maxn);
    beat_t e;
    for (int k = skip; k < total; k++) begin
      if ((k - skip) < MAX && (k - skip) < maxn) begin
        e.data = {2'(port), start + 6'(k)};
        e.last = (k == total - 1) || ((k - skip) == MAX - 1);
        e.src  = 2'(port);
        exp_q.push_back(e);
      end
    end
  endtask

  // One clock cycle: sample at the falling edge, then apply the pops the DUT requested.
  task automatic step();
    logic [NP-1:0] rd_s;
    logic [3:0]    onehot;
    beat_t         e;
    @(negedge CLK);
    rd_s = FIFO_RD_EN;
    if (TRUNC) trunc_cnt++;
    if (OUT_VALID) check("busy_xfer", 32'(BUSY), 32'd1);
    if (OUT_VALID && OUT_READY) begin
      check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        onehot = 4'b0001 << e.src;
        check("data", 32'(OUT_DATA), 32'(e.data));
        check("last", 32'(OUT_LAST), 32'(e.last));
        check("src",  32'(OUT_SRC),  32'(e.src));
        check("rd_en_beat", 32'(FIFO_RD_EN), 32'(onehot));
        $display("beat src=%0d data=%02h last=%0d", OUT_SRC, OUT_DATA, OUT_LAST);
      end
    end else if (OUT_VALID) begin
      stall_cnt++;
      check("stall_rd_en", 32'(FIFO_RD_EN), 32'd0);
      if (exp_q.size() != 0) begin
        check("stall_data", 32'(OUT_DATA), 32'(exp_q[0].data));
        check("stall_last", 32'(OUT_LAST), 32'(exp_q[0].last));
      end
    end
    @(posedge CLK);
    #1;
    for (int i = 0; i < NP; i++) begin
      if (rd_s[i]) begin
        check("pop_nonempty", 32'(fifo_q[i].size() != 0), 32'd1);
        if (fifo_q[i].size() != 0) void'(fifo_q[i].pop_front());
      end
    end
    refresh();
  endtask

  task automatic drain(input int budget, output int cycles);
    cycles = 0;
    while (exp_q.size() != 0 && cycles < budget) begin
      step();
      cycles++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    logic [5:0] s0, s1, s2, s3, s4;
    int         cyc;
    n_vec = 0; n_err = 0; trunc_cnt = 0; stall_cnt = 0; seq_ctr = 6'd0;
    RST = 1'b1; OUT_READY = 1'b1; PORT_EN = 4'b1111;
    FIFO_DATA = '0; FIFO_EMPTY = '1;
    refresh();

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_valid", 32'(OUT_VALID), 32'd0);
    check("rst_rd_en", 32'(FIFO_RD_EN), 32'd0);
    check("rst_last",  32'(OUT_LAST), 32'd0);
    check("rst_src",   32'(OUT_SRC), 32'd0);
    check("rst_trunc", 32'(TRUNC), 32'd0);
    check("rst_busy",  32'(BUSY), 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;

    // Round robin: 2-word frames everywhere plus a second port-0 frame -> 0,1,2,3,0
    load_frame(0, 2, s0); load_frame(1, 2, s1); load_frame(2, 2, s2);
    load_frame(3, 2, s3); load_frame(0, 2, s4);
    expect_frame(0, s0, 2, 0, 4); expect_frame(1, s1, 2, 0, 4); expect_frame(2, s2, 2, 0, 4);
    expect_frame(3, s3, 2, 0, 4); expect_frame(0, s4, 2, 0, 4);
    drain(100, cyc);
    check("rr_cycles", 32'(cyc), 32'd15);

    // Single 3-word frame on port 1: one bubble then 3 beats
    load_frame(1, 3, s1);
    expect_frame(1, s1, 3, 0, 4);
    drain(50, cyc);
    check("single_cycles", 32'(cyc), 32'd4);

    // Backpressure mid-frame on an exactly-limit-length frame (must not truncate)
    trunc_cnt = 0; stall_cnt = 0;
    load_frame(1, 4, s1);
    expect_frame(1, s1, 4, 0, 4);
    step(); step();
    OUT_READY = 1'b0;
    repeat (5) step();
    OUT_READY = 1'b1;
    drain(50, cyc);
    check("stall_cycles", 32'(stall_cnt), 32'd5);
    check("exact_max_trunc", 32'(trunc_cnt), 32'd0);

    // Truncation: 7-word frame on port 2, then an intact frame on port 3
    trunc_cnt = 0;
    load_frame(2, 7, s2); load_frame(3, 2, s3);
    expect_frame(2, s2, 7, 0, 4); expect_frame(3, s3, 2, 0, 4);
    drain(100, cyc);
    check("trunc_pulses", 32'(trunc_cnt), 32'd1);
    check("trunc_port2_left", 32'(fifo_q[2].size()), 32'd0);
    check("trunc_port3_left", 32'(fifo_q[3].size()), 32'd0);

    // Enable mask: only 1 and 3 eligible; port 1 disabled mid-frame still completes
    PORT_EN = 4'b1010;
    load_frame(0, 2, s0); load_frame(1, 2, s1); load_frame(1, 2, s4);
    load_frame(2, 2, s2); load_frame(3, 2, s3);
    expect_frame(1, s1, 2, 0, 4); expect_frame(3, s3, 2, 0, 4);
    step(); step();
    PORT_EN = 4'b1000;
    drain(50, cyc);
    repeat (3) step();
    check("mask_port0_left", 32'(fifo_q[0].size()), 32'd2);
    check("mask_port1_left", 32'(fifo_q[1].size()), 32'd2);
    check("mask_port2_left", 32'(fifo_q[2].size()), 32'd2);
    PORT_EN = 4'b1111;
    expect_frame(0, s0, 2, 0, 4); expect_frame(1, s4, 2, 0, 4); expect_frame(2, s2, 2, 0, 4);
    drain(50, cyc);

    // Reset during beat 2 of a port-0 frame; the next grant is port 0 again
    load_frame(0, 4, s0); load_frame(1, 2, s1);
    expect_frame(0, s0, 4, 0, 2);
    step(); step();
    RST = 1'b1;
    step();
    @(negedge CLK);
    check("rstmid_valid", 32'(OUT_VALID), 32'd0);
    check("rstmid_busy",  32'(BUSY), 32'd0);
    check("rstmid_rd_en", 32'(FIFO_RD_EN), 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    expect_frame(0, s0, 4, 2, 4); expect_frame(1, s1, 2, 0, 4);
    drain(50, cyc);
    for (int i = 0; i < NP; i++) begin
      check("final_empty", 32'(fifo_q[i].size()), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
